// File: rtl/sdram_wr_packer.sv
// Write-feed stage: packs 16-bit words into 4-word bursts, tags them with a
// sequential SDRAM address and queues them for the controller.
module sdram_wr_packer #(
    parameter int DW = 16,
    parameter int DEPTH = 8,
    parameter int ADDR_W = 26,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                       sclk,
    input  logic                       srst_n,
    input  logic [DW-1:0]              in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_flush,
    input  logic                       addr_clr,
    output logic [3:0][DW-1:0]         writeData,
    output logic [13:0]                row,
    output logic [8:0]                 col,
    output logic [2:0]                 ba,
    output logic                       writeDataTrig,
    input  logic                       writeDataClk,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [3:0][DW-1:0] words_q;
    logic [1:0]         cnt;
    logic [ADDR_W-1:0]  addr;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;

    logic [3:0][DW-1:0] mem_data [DEPTH];
    logic [ADDR_W-1:0]  mem_addr [DEPTH];

    logic               accept;
    logic               full;
    logic               push;
    logic               pop;
    logic [2:0]         fill;
    logic [3:0][DW-1:0] push_words;
    logic [LW-1:0]      level_next;
    logic [ADDR_W-1:0]  head_addr;

    always_comb begin
        accept = in_valid & in_ready;
        full = (level == LW'(DEPTH));
        fill = {1'b0, cnt} + {2'b00, accept};
        // The incoming word lands before a same-cycle flush closes the burst
        push = (accept && cnt == 2'd3) ||
               (in_flush && !full && fill != 3'd0);
        pop = writeDataTrig & writeDataClk;
        level_next = level + LW'(push) - LW'(pop);
        push_words = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < int'(cnt)) begin
                push_words[i] = words_q[i];
            end else if (i == int'(cnt) && accept) begin
                push_words[i] = in_data;
            end else begin
                push_words[i] = '0;
            end
        end
        head_addr = mem_addr[rd_ptr];
    end

    always_ff @(posedge sclk) begin
        if (push) begin
            mem_data[wr_ptr] <= push_words;
            mem_addr[wr_ptr] <= addr;
        end
    end

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            words_q <= '0;
            cnt <= '0;
            addr <= BASE_ADDR;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
            in_ready <= 1'b0;
            writeDataTrig <= 1'b0;
            writeData <= '0;
            row <= '0;
            col <= '0;
            ba <= '0;
        end else begin
            if (accept) begin
                words_q[cnt] <= in_data;
                cnt <= cnt + 2'd1;
            end
            if (push) begin
                cnt <= '0;
                addr <= addr + ADDR_W'(4);
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (addr_clr) begin
                addr <= BASE_ADDR;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level_next;
            in_ready <= (level_next != LW'(DEPTH));
            // A pop always leaves one idle cycle before the next head shows
            if (pop) begin
                writeDataTrig <= 1'b0;
            end else if (!writeDataTrig && level != '0) begin
                writeDataTrig <= 1'b1;
                writeData <= mem_data[rd_ptr];
                ba <= head_addr[ADDR_W-1 -: 3];
                row <= head_addr[ADDR_W-4 -: 14];
                col <= head_addr[8:0];
            end
        end
    end

endmodule

// File: tb/tb_sdram_wr_packer.sv
// Scoreboard bench for sdram_wr_packer: a reference model queues expected
// bursts as words are fed, and each controller ack pops and compares one.
module tb_sdram_wr_packer;

    logic        sclk = 1'b0;
    logic        srst_n;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_flush;
    logic        addr_clr;
    logic [3:0][15:0] writeData;
    logic [13:0] row;
    logic [8:0]  col;
    logic [2:0]  ba;
    logic        writeDataTrig;
    logic        writeDataClk;
    logic [3:0]  level;

    logic        w_rst_n;
    logic [15:0] w_in_data;
    logic        w_in_valid;
    logic        w_in_ready;
    logic        w_in_flush;
    logic        w_addr_clr;
    logic [3:0][15:0] w_data;
    logic [13:0] w_row;
    logic [8:0]  w_col;
    logic [2:0]  w_ba;
    logic        w_trig;
    logic        w_clk;
    logic [3:0]  w_level;

    always #5 sclk = ~sclk;

    sdram_wr_packer dut (
        .sclk(sclk), .srst_n(srst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_flush(in_flush), .addr_clr(addr_clr),
        .writeData(writeData), .row(row), .col(col), .ba(ba),
        .writeDataTrig(writeDataTrig), .writeDataClk(writeDataClk),
        .level(level)
    );

    sdram_wr_packer #(.BASE_ADDR(26'h3FFFFFC)) wdut (
        .sclk(sclk), .srst_n(w_rst_n),
        .in_data(w_in_data), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_flush(w_in_flush), .addr_clr(w_addr_clr),
        .writeData(w_data), .row(w_row), .col(w_col), .ba(w_ba),
        .writeDataTrig(w_trig), .writeDataClk(w_clk),
        .level(w_level)
    );

    typedef struct packed {
        logic [25:0] a;
        logic [63:0] d;
    } burst_t;

    burst_t      q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_w[4];
    int          m_cnt = 0;
    logic [25:0] m_addr = '0;

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    function automatic void m_push();
        burst_t b;
        b.a = m_addr;
        b.d = {m_w[3], m_w[2], m_w[1], m_w[0]};
        q.push_back(b);
        m_addr = m_addr + 26'd4;
        m_cnt = 0;
        for (int i = 0; i < 4; i++) m_w[i] = '0;
    endfunction

    function automatic void m_word(input logic [15:0] d);
        m_w[m_cnt] = d;
        m_cnt++;
        if (m_cnt == 4) m_push();
    endfunction

    function automatic void m_reset();
        q.delete();
        m_cnt = 0;
        m_addr = '0;
        for (int i = 0; i < 4; i++) m_w[i] = '0;
    endfunction

    task automatic send_word(input logic [15:0] d);
        int t = 0;
        in_valid = 1'b1;
        in_data = d;
        while (!in_ready && t < 50) begin
            step();
            t++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        step();
        in_valid = 1'b0;
        m_word(d);
    endtask

    task automatic ack_one();
        burst_t e;
        int t = 0;
        while (!writeDataTrig && t < 20) begin
            step();
            t++;
        end
        checks++;
        if (!writeDataTrig) begin
            errors++;
            $display("FAIL ack_timeout: trig=%0b required 1", writeDataTrig);
            return;
        end
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL extra_burst: got %h with empty scoreboard", writeData);
        end else begin
            e = q.pop_front();
            if (writeData !== e.d) begin
                errors++;
                $display("FAIL burst_data: got %h required %h", writeData, e.d);
            end
            checks++;
            if ({ba, row, col} !== e.a) begin
                errors++;
                $display("FAIL burst_addr: got %h required %h",
                         {ba, row, col}, e.a);
            end
        end
        writeDataClk = 1'b1;
        step();
        writeDataClk = 1'b0;
        checks++;
        if (writeDataTrig !== 1'b0) begin
            errors++;
            $display("FAIL trig_gap: trig=%0b required 0", writeDataTrig);
        end
    endtask

    task automatic drain();
        int n = q.size();
        repeat (n) ack_one();
        checks++;
        if (level !== 4'd0) begin
            errors++;
            $display("FAIL drain_level: level=%0d required 0", level);
        end
    endtask

    task automatic do_flush();
        in_flush = 1'b1;
        step();
        in_flush = 1'b0;
        if (m_cnt > 0) m_push();
    endtask

    task automatic test_reset();
        srst_n = 1'b0;
        w_rst_n = 1'b0;
        {in_data, in_valid, in_flush, addr_clr, writeDataClk} = '0;
        {w_in_data, w_in_valid, w_in_flush, w_addr_clr, w_clk} = '0;
        m_reset();
        #12;
        checks++;
        if ({writeDataTrig, level, in_ready} !== 6'd0) begin
            errors++;
            $display("FAIL reset_ctl: trig/level/ready=%b required 0",
                     {writeDataTrig, level, in_ready});
        end
        checks++;
        if ({writeData, ba, row, col} !== 90'd0) begin
            errors++;
            $display("FAIL reset_out: data/addr=%h required 0",
                     {writeData, ba, row, col});
        end
        #2;
        srst_n = 1'b1;
        w_rst_n = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%0b required 1", in_ready);
        end
    endtask

    task automatic test_single();
        for (int i = 0; i < 4; i++) send_word(16'(i));
        checks++;
        if (writeDataTrig !== 1'b0) begin
            errors++;
            $display("FAIL single_early: trig=%0b required 0", writeDataTrig);
        end
        step();
        checks++;
        if (writeDataTrig !== 1'b1 || level !== 4'd1) begin
            errors++;
            $display("FAIL single_trig: trig=%0b level=%0d required 1 1",
                     writeDataTrig, level);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) send_word(16'h200 + 16'(i));
        checks++;
        if (level !== 4'd4) begin
            errors++;
            $display("FAIL b2b_level: level=%0d required 4", level);
        end
        drain();
    endtask

    task automatic test_full();
        for (int i = 0; i < 32; i++) send_word(16'h100 + 16'(i));
        checks++;
        if (level !== 4'd8 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_state: level=%0d ready=%0b required 8 0",
                     level, in_ready);
        end
        in_valid = 1'b1;
        in_data = 16'hDEAD;
        repeat (3) step();
        in_valid = 1'b0;
        checks++;
        if (level !== 4'd8 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_hold: level=%0d ready=%0b required 8 0",
                     level, in_ready);
        end
        ack_one();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_release: in_ready=%0b required 1", in_ready);
        end
        for (int i = 0; i < 3; i++) send_word(16'h120 + 16'(i));
        checks++;
        if (level !== 4'd7) begin
            errors++;
            $display("FAIL full_refill: level=%0d required 7", level);
        end
        do_flush();
        drain();
    endtask

    task automatic test_flush();
        send_word(16'h11);
        send_word(16'h22);
        do_flush();
        checks++;
        if (level !== 4'd1) begin
            errors++;
            $display("FAIL flush_push: level=%0d required 1", level);
        end
        do_flush();
        checks++;
        if (level !== 4'd1) begin
            errors++;
            $display("FAIL flush_noop: level=%0d required 1", level);
        end
        in_valid = 1'b1;
        in_flush = 1'b1;
        in_data = 16'h33;
        step();
        {in_valid, in_flush} = '0;
        m_word(16'h33);
        m_push();
        for (int i = 0; i < 3; i++) send_word(16'h40 + 16'(i));
        in_valid = 1'b1;
        in_flush = 1'b1;
        in_data = 16'h43;
        step();
        {in_valid, in_flush} = '0;
        m_word(16'h43);
        checks++;
        if (level !== 4'd3) begin
            errors++;
            $display("FAIL flush_fourth: level=%0d required 3", level);
        end
        drain();
    endtask

    task automatic test_addr_clr();
        for (int i = 0; i < 3; i++) send_word(16'h50 + 16'(i));
        in_valid = 1'b1;
        addr_clr = 1'b1;
        in_data = 16'h53;
        step();
        {in_valid, addr_clr} = '0;
        m_word(16'h53);
        m_addr = '0;
        for (int i = 0; i < 4; i++) send_word(16'h60 + 16'(i));
        drain();
    endtask

    task automatic test_wrap();
        w_in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w_in_data = 16'(i);
            step();
        end
        w_in_valid = 1'b0;
        checks++;
        if (w_level !== 4'd2) begin
            errors++;
            $display("FAIL wrap_level: level=%0d required 2", w_level);
        end
        checks++;
        if (!w_trig || {w_ba, w_row, w_col} !== 26'h3FFFFFC ||
            w_data !== 64'h0003_0002_0001_0000) begin
            errors++;
            $display("FAIL wrap_first: trig=%0b addr=%h data=%h",
                     w_trig, {w_ba, w_row, w_col}, w_data);
        end
        w_clk = 1'b1;
        step();
        w_clk = 1'b0;
        step();
        checks++;
        if (!w_trig || {w_ba, w_row, w_col} !== 26'h0 ||
            w_data !== 64'h0007_0006_0005_0004) begin
            errors++;
            $display("FAIL wrap_second: trig=%0b addr=%h data=%h",
                     w_trig, {w_ba, w_row, w_col}, w_data);
        end
        w_clk = 1'b1;
        step();
        w_clk = 1'b0;
        w_addr_clr = 1'b1;
        step();
        w_addr_clr = 1'b0;
        w_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w_in_data = 16'h70 + 16'(i);
            step();
        end
        w_in_valid = 1'b0;
        step();
        checks++;
        if (!w_trig || {w_ba, w_row, w_col} !== 26'h3FFFFFC) begin
            errors++;
            $display("FAIL wrap_clr: trig=%0b addr=%h required 1 3fffffc",
                     w_trig, {w_ba, w_row, w_col});
        end
        w_clk = 1'b1;
        step();
        w_clk = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 10; i++) send_word(16'h80 + 16'(i));
        checks++;
        if (level !== 4'd2) begin
            errors++;
            $display("FAIL rmid_pre: level=%0d required 2", level);
        end
        #2;
        srst_n = 1'b0;
        #1;
        checks++;
        if ({writeDataTrig, level, in_ready} !== 6'd0) begin
            errors++;
            $display("FAIL rmid_reset: trig/level/ready=%b required 0",
                     {writeDataTrig, level, in_ready});
        end
        m_reset();
        step();
        #3;
        srst_n = 1'b1;
        step();
        for (int i = 0; i < 4; i++) send_word(16'h90 + 16'(i));
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_flush();
        test_addr_clr();
        test_wrap();
        test_reset_mid();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d bursts unread, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
